branch_history_unit: RTL

BRANCH_HISTORY_UNIT -- requirements
Module: branch_history_unit

---
 rtl/lc3b_types.sv | 15 +
 rtl/branch_checkpoint_fifo.sv | 71 +++++++
 rtl/branch_history_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared types for the branch history unit: default history width and the
// layout of one in-flight branch checkpoint.
package lc3b_types;

    localparam int TABLE_INDEX = 7;
    localparam int QUEUE_DEPTH = 8;

    // Checkpoint saved per predicted branch: the PHT slot it used and the
    // global history in effect when it was predicted.
    typedef struct packed {
        logic [TABLE_INDEX-1:0] index;
        logic [TABLE_INDEX-1:0] ghr;
    } bq_entry_t;

endpackage

// File: rtl/branch_checkpoint_fifo.sv
// In-order queue of branch checkpoints. Flush overrides push and pop in the
// same cycle; callers never push when full or pop when empty.
module branch_checkpoint_fifo
    import lc3b_types::*;
#(
    parameter int  depth   = QUEUE_DEPTH,
    parameter type entry_t = bq_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   flush,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int aw = $clog2(depth);

    logic [aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [aw:0]   count_q, count_d;
    entry_t        mem_q [depth];
    entry_t        mem_d [depth];

    // Pointers are exactly log2(depth) bits wide, so increments wrap modulo depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + aw'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + aw'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (aw+1)'(1);
                2'b01:   count_d = count_q - (aw+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign full  = (count_q == (aw+1)'(depth));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/branch_history_unit.sv
// Gshare index generation with speculative global history, checkpointed per
// in-flight branch so a mispredict can restore history and retrain the PHT.
module branch_history_unit
    import lc3b_types::*;
#(
    parameter int table_index = TABLE_INDEX,
    parameter int queue_depth = QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_req,
    input  logic [15:0]            pred_pc,
    input  logic                   pred_taken,
    output logic [table_index-1:0] pht_pred_ind,
    output logic                   pred_stall,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    input  logic                   resolve_mispredict,
    output logic                   ld_pht,
    output logic                   taken_in,
    output logic [table_index-1:0] pht_taken_ind,
    output logic [table_index-1:0] ghr
);

    typedef struct packed {
        logic [table_index-1:0] index;
        logic [table_index-1:0] ghr;
    } entry_t;

    logic [table_index-1:0] ghr_q, ghr_d;
    logic [table_index-1:0] upd_ind_q, upd_ind_d;
    logic                   ld_pht_q, ld_pht_d;
    logic                   taken_in_q, taken_in_d;
    logic                   do_pop, do_flush, accept;
    logic                   fifo_full, fifo_empty;
    entry_t                 push_entry, head_entry;
    logic                   unused_bits;

    assign unused_bits = ^{pred_pc[15:table_index+1], pred_pc[0], head_entry.ghr[table_index-1]};

    // Handshake: a branch is taken when pred_req is high and pred_stall is low
    // in the same cycle; resolve_valid is a one-cycle strobe for the oldest entry.
    always_comb begin
        pht_pred_ind    = pred_pc[table_index:1] ^ ghr_q;
        do_pop          = resolve_valid && !fifo_empty;
        do_flush        = do_pop && resolve_mispredict;
        accept          = pred_req && !fifo_full && !do_flush;
        push_entry      = '{index: pht_pred_ind, ghr: ghr_q};

        ghr_d = ghr_q;
        if (do_flush) begin
            ghr_d = {head_entry.ghr[table_index-2:0], resolve_taken};
        end else if (accept) begin
            ghr_d = {ghr_q[table_index-2:0], pred_taken};
        end

        ld_pht_d   = do_pop;
        taken_in_d = do_pop && resolve_taken;
        upd_ind_d  = do_pop ? head_entry.index : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q      <= '0;
            ld_pht_q   <= 1'b0;
            taken_in_q <= 1'b0;
            upd_ind_q  <= '0;
        end else begin
            ghr_q      <= ghr_d;
            ld_pht_q   <= ld_pht_d;
            taken_in_q <= taken_in_d;
            upd_ind_q  <= upd_ind_d;
        end
    end

    branch_checkpoint_fifo #(
        .depth   (queue_depth),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_entry),
        .pop       (do_pop),
        .flush     (do_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    assign pred_stall    = fifo_full;
    assign ld_pht        = ld_pht_q;
    assign taken_in      = taken_in_q;
    assign pht_taken_ind = upd_ind_q;
    assign ghr           = ghr_q;

endmodule
